// File: rtl/clock_pkg.sv
// ============================================================================
// Module      : clock_pkg
// Description : Shared widths, blank code and display-format enum for the
//               hour counter and its BCD decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;
  localparam int HOUR_W = 5;
  localparam int BCD_W  = 4;
  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

  typedef enum logic {
    FMT12 = 1'b0,
    FMT24 = 1'b1
  } hour_fmt_t;
endpackage

`default_nettype wire

// File: rtl/hour_bcd_decode.sv
// ============================================================================
// Module      : hour_bcd_decode
// Description : Combinational binary-hour to BCD tens/ones in 12h or 24h form.
//               Optional macro HOUR_LEAD_BLANK_EN blanks a 12h leading zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hour_bcd_decode
  import clock_pkg::*;
(
  input  logic [HOUR_W-1:0] hour,
  input  hour_fmt_t         fmt,
  output logic [BCD_W-1:0]  tens,
  output logic [BCD_W-1:0]  ones
);

  logic [HOUR_W-1:0] h12;
  logic [HOUR_W-1:0] val;
  logic [BCD_W-1:0]  tens_raw;
  logic [BCD_W-1:0]  sub_lo;

  always_comb begin
    h12 = (hour >= HOUR_W'(12)) ? hour - HOUR_W'(12) : hour;
    if (h12 == '0) h12 = HOUR_W'(12);
    val = (fmt == FMT24) ? hour : h12;

    // val - 10*tens is below 10, so subtracting the low nibble mod 16 is exact.
    if (val >= HOUR_W'(30)) begin
      tens_raw = 4'd3;
      sub_lo   = 4'd14;
    end else if (val >= HOUR_W'(20)) begin
      tens_raw = 4'd2;
      sub_lo   = 4'd4;
    end else if (val >= HOUR_W'(10)) begin
      tens_raw = 4'd1;
      sub_lo   = 4'd10;
    end else begin
      tens_raw = 4'd0;
      sub_lo   = 4'd0;
    end

    ones = val[BCD_W-1:0] - sub_lo;
    tens = tens_raw;
`ifdef HOUR_LEAD_BLANK_EN
    if ((fmt == FMT12) && (tens_raw == 4'd0)) tens = BCD_BLANK;
`else
`endif
  end

endmodule

`default_nettype wire

// File: rtl/hour_counter_bcd.sv
// ============================================================================
// Module      : hour_counter_bcd
// Description : Hour counter (mod 12/24) with load, day carry and registered
//               BCD display. Optional macro HOUR_LEAD_BLANK_EN (see decoder).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hour_counter_bcd
  import clock_pkg::*;
#(
  parameter int MOD        = 24,
  parameter int RESET_HOUR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              set_en,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic              mode24,
  output logic [HOUR_W-1:0] hour_bin,
  output logic [BCD_W-1:0]  hour10,
  output logic [BCD_W-1:0]  hour1,
  output logic              pm,
  output logic              day_carry,
  output logic              set_err
);

  generate
    if ((MOD != 12) && (MOD != 24)) begin : g_bad_mod
      $error("hour_counter_bcd: MOD must be 12 or 24");
    end
    if ((RESET_HOUR < 0) || (RESET_HOUR >= MOD)) begin : g_bad_reset
      $error("hour_counter_bcd: RESET_HOUR must be in 0..MOD-1");
    end
  endgenerate

  localparam logic [HOUR_W-1:0] MOD_V    = HOUR_W'(MOD);
  localparam logic [HOUR_W-1:0] LAST_V   = HOUR_W'(MOD - 1);
  localparam logic [HOUR_W-1:0] RESET_V  = HOUR_W'(RESET_HOUR);
  localparam logic [BCD_W-1:0]  RST_TENS = BCD_W'(RESET_HOUR / 10);
  localparam logic [BCD_W-1:0]  RST_ONES = BCD_W'(RESET_HOUR % 10);
  localparam logic              RST_PM   = (MOD == 24) && (RESET_HOUR >= 12);

  logic [HOUR_W-1:0] hour_bin_q, hour_bin_d;
  logic [BCD_W-1:0]  hour10_q, hour10_d;
  logic [BCD_W-1:0]  hour1_q, hour1_d;
  logic              pm_q, pm_d;
  logic              day_carry_q, day_carry_d;
  logic              set_err_q, set_err_d;
  logic              armed_q, armed_d;
  hour_fmt_t         fmt;
  logic [BCD_W-1:0]  dec_tens;
  logic [BCD_W-1:0]  dec_ones;

  hour_bcd_decode u_decode (
    .hour (hour_bin_q),
    .fmt  (fmt),
    .tens (dec_tens),
    .ones (dec_ones)
  );

  always_comb begin
    fmt         = mode24 ? FMT24 : FMT12;
    hour_bin_d  = hour_bin_q;
    day_carry_d = 1'b0;
    set_err_d   = 1'b0;
    armed_d     = 1'b1;

    // armed_q stays low through the first edge after reset release.
    if (armed_q) begin
      if (set_en) begin
        if (set_hour >= MOD_V) set_err_d = 1'b1;
        else                   hour_bin_d = set_hour;
      end else if (tick) begin
        if (hour_bin_q == LAST_V) begin
          hour_bin_d  = '0;
          day_carry_d = 1'b1;
        end else begin
          hour_bin_d = hour_bin_q + HOUR_W'(1);
        end
      end
    end

    hour10_d = dec_tens;
    hour1_d  = dec_ones;
    pm_d     = (MOD == 24) ? (hour_bin_q >= HOUR_W'(12)) : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hour_bin_q  <= RESET_V;
      hour10_q    <= RST_TENS;
      hour1_q     <= RST_ONES;
      pm_q        <= RST_PM;
      day_carry_q <= 1'b0;
      set_err_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      hour_bin_q  <= hour_bin_d;
      hour10_q    <= hour10_d;
      hour1_q     <= hour1_d;
      pm_q        <= pm_d;
      day_carry_q <= day_carry_d;
      set_err_q   <= set_err_d;
      armed_q     <= armed_d;
    end
  end

  assign hour_bin  = hour_bin_q;
  assign hour10    = hour10_q;
  assign hour1     = hour1_q;
  assign pm        = pm_q;
  assign day_carry = day_carry_q;
  assign set_err   = set_err_q;

endmodule

`default_nettype wire
